toggle_driver: RTL and testbench
================================

Name: toggle_driver

Overview:
- Upstream stimulus stage for the Toggle block: generates the `ready` waveform that Toggle consumes.
- Runs a programmed number of ready-high bursts, each of fixed length and separated by fixed gaps.
- Observes Toggle's `output1` and `done` during the run and reports the rising-edge count and a sticky done flag.
- Replaces hand-timed `ready` stimulus with a repeatable, self-checking driver.

Parameters:
- CNT_W, 8, width of high/low length counters and of edge_count.
- BURST_W, 4, width of the burst-count field.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- high_len  in  CNT_W  ready-high cycles per burst; latched on an accepted start.
- low_len  in  CNT_W  ready-low gap cycles between bursts; latched on an accepted start.
- bursts  in  BURST_W  number of bursts; latched on an accepted start.
- tog_out  in  1  Toggle's output1.
- tog_done  in  1  Toggle's done.
- ready  out  1  drives Toggle's ready input; registered.
- busy  out  1  high while a sequence runs.
- finished  out  1  one-cycle completion pulse.
- edge_count  out  CNT_W  rising edges of tog_out seen while busy; saturating.
- done_seen  out  1  sticky: tog_done was sampled high while busy.

Behaviour:
- Reset (async): ready=0, busy=0, finished=0, edge_count=0, done_seen=0, state=IDLE, all counters 0. Asserting reset mid-run drops ready in the same instant.
- States: IDLE, HIGH, LOW, FIN.
- IDLE, start=1, bursts≠0 and high_len≠0:
  - latch all parameters; clear edge_count and done_seen;
  - next state HIGH; ready=1 and busy=1 from the cycle after start.
- IDLE, start=1, bursts=0 or high_len=0: next state FIN; ready never rises; edge_count and done_seen are cleared.
- HIGH:
  - ready=1 for exactly high_len cycles;
  - on the last cycle, if bursts_left>1 go to LOW, else go to FIN.
- LOW:
  - ready=0 for max(low_len,1) cycles, so low_len=0 still gives a 1-cycle gap and bursts never merge;
  - decrement bursts_left, then go to HIGH.
- FIN: exactly one cycle; finished=1, busy=0, ready=0; then IDLE.
- Start outside IDLE (HIGH, LOW, FIN) is ignored; there is no queuing.
- Edge detection:
  - tog_out is registered into prev each cycle;
  - a rise is sampled tog_out=1 with prev=0, counted only while busy=1;
  - edge_count saturates at 2^CNT_W−1 with no wrap;
  - prev updates while idle, so a level already high at start does not count.
- done_seen is set on any cycle with busy=1 and tog_done=1, and holds until the next accepted start or reset.
- edge_count and done_seen stay stable after FIN until the next accepted start.
- Total run length from start to finished: 1 + bursts·high_len + (bursts−1)·max(low_len,1) + 1 cycles.
- All arithmetic is unsigned. Counters are loaded with length−1 and count down to 0.

Decomposition:
- Package toggle_pkg:
  - state enum {IDLE, HIGH, LOW, FIN};
  - default CNT_W and BURST_W constants.
- Sub-module toggle_edge_counter:
  - contains the prev register, the rise detect, the saturating edge_count and the sticky done_seen;
  - gated by busy, cleared by a clr pulse asserted on accepted start.
- The FSM and length counters stay in the top level.

Test Plan:
- Reset, then start with high_len=4, low_len=4, bursts=2 → ready high on cycles 1–4 and 9–12 after start, low on 5–8; finished pulses on cycle 13; busy low on that same cycle.
- bursts=0 on start → finished on the next cycle, ready stays 0, edge_count=0.
- low_len=0, high_len=2, bursts=3 → ready pattern 1,1,0,1,1,0,1,1 and never a merged burst; finished follows.
- Drive tog_out with 300 rising edges while busy, CNT_W=8 → edge_count=255; a tog_out edge injected in IDLE before start → not counted.
- tog_done pulsed 1 cycle mid-run → done_seen=1, held through finished; cleared on the next start.
- Assert reset during HIGH → ready, busy and finished read 0 immediately (before the next clock); a start after reset runs a full clean sequence.

Source files
------------

// File: rtl/toggle_pkg.sv
// Shared types and defaults for the Toggle stimulus driver.
// State encoding and default widths are used by the driver and its edge counter.
package toggle_pkg;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_BURST_W = 4;

  typedef enum logic [1:0] {IDLE, HIGH, LOW, FIN} state_e;
endpackage

// File: rtl/toggle_edge_counter.sv
// Counts rising edges of Toggle's output1 while a run is active (saturating)
// and keeps a sticky flag for Toggle's done.
module toggle_edge_counter
  import toggle_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             busy,
  input  logic             tog_out,
  input  logic             tog_done,
  output logic [CNT_W-1:0] edge_count,
  output logic             done_seen
);
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             rise;

  always_comb begin
    // prev tracks the level even while idle, so a level already high at start is not a rise
    prev_d = tog_out;
    rise   = busy & tog_out & ~prev_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (clr) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else begin
      if (rise && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
      if (busy && tog_done) done_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign edge_count = cnt_q;
  assign done_seen  = done_q;
endmodule

// File: rtl/toggle_driver.sv
// Generates a programmed train of ready-high bursts for the Toggle block and
// reports Toggle's rising-edge count and done observation for the run.
module toggle_driver
  import toggle_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   high_len,
  input  logic [CNT_W-1:0]   low_len,
  input  logic [BURST_W-1:0] bursts,
  input  logic               tog_out,
  input  logic               tog_done,
  output logic               ready,
  output logic               busy,
  output logic               finished,
  output logic [CNT_W-1:0]   edge_count,
  output logic               done_seen
);
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     high_q, high_d;
  logic [CNT_W-1:0]     low_q, low_d;
  logic [BURST_W-1:0]   left_q, left_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 fin_q, fin_d;
  logic                 clr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    high_d  = high_q;
    low_d   = low_q;
    left_d  = left_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    fin_d   = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          clr = 1'b1;
          if (bursts != '0 && high_len != '0) begin
            high_d  = high_len;
            low_d   = low_len;
            left_d  = bursts;
            cnt_d   = high_len - CNT_W'(1);
            state_d = HIGH;
            ready_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = FIN;
            fin_d   = 1'b1;
          end
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          ready_d = 1'b0;
          if (left_q > BURST_W'(1)) begin
            // a zero gap still costs one cycle so bursts never merge
            cnt_d   = (low_q == '0) ? '0 : low_q - CNT_W'(1);
            state_d = LOW;
          end else begin
            busy_d  = 1'b0;
            fin_d   = 1'b1;
            state_d = FIN;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LOW: begin
        if (cnt_q == '0) begin
          left_d  = left_q - BURST_W'(1);
          cnt_d   = high_q - CNT_W'(1);
          ready_d = 1'b1;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FIN: begin
        ready_d = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      high_q  <= '0;
      low_q   <= '0;
      left_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      high_q  <= high_d;
      low_q   <= low_d;
      left_q  <= left_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign finished = fin_q;

  toggle_edge_counter #(.CNT_W(CNT_W)) u_edge (
    .clock      (clock),
    .reset      (reset),
    .clr        (clr),
    .busy       (busy_q),
    .tog_out    (tog_out),
    .tog_done   (tog_done),
    .edge_count (edge_count),
    .done_seen  (done_seen)
  );
endmodule

// File: tb/tb_toggle_driver.sv
// Randomized scoreboard bench for toggle_driver: each run's expected waveform
// and observations are queued at start and checked when finished pulses.
module tb_toggle_driver;
  localparam int CW = 8;
  localparam int BW = 4;
  localparam int HW = 1024;

  logic          clock = 1'b0;
  logic          reset, start, tog_out, tog_done;
  logic [CW-1:0] high_len, low_len;
  logic [BW-1:0] bursts;
  logic          ready, busy, finished, done_seen;
  logic [CW-1:0] edge_count;

  toggle_driver #(.CNT_W(CW), .BURST_W(BW)) dut (
    .clock(clock), .reset(reset), .start(start), .high_len(high_len),
    .low_len(low_len), .bursts(bursts), .tog_out(tog_out), .tog_done(tog_done),
    .ready(ready), .busy(busy), .finished(finished), .edge_count(edge_count),
    .done_seen(done_seen)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          fin_cyc;
    int          n;
    logic [HW-1:0] rdy;
    logic [HW-1:0] bsy;
    int          cnt;
    bit          dn;
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0;
  int   cyc = 0;
  bit   last_tog = 1'b0;
  int   prev_cnt = 0;
  bit   prev_dn = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: keeps a history of ready/busy and scores a run on each finished pulse
  logic [HW-1:0] hr = '0, hb = '0;
  always @(negedge clock) begin : mon
    logic [HW-1:0] hr_now, hb_now;
    exp_t e;
    int mr, mb;
    hr_now = {hr[HW-2:0], ready};
    hb_now = {hb[HW-2:0], busy};
    hr <= hr_now;
    hb <= hb_now;
    if (!reset && finished) begin
      if (q.size() == 0) begin
        chk("unexpected_finished", 1, 0);
      end else begin
        e = q.pop_front();
        mr = 0; mb = 0;
        for (int i = 0; i <= e.n + 1; i++) begin
          if (hr_now[e.n + 1 - i] !== e.rdy[i]) mr++;
          if (hb_now[e.n + 1 - i] !== e.bsy[i]) mb++;
        end
        chk("finish_cycle", cyc, e.fin_cyc);
        chk("ready_wave_mismatches", mr, 0);
        chk("busy_wave_mismatches", mb, 0);
        chk("edge_count", edge_count, e.cnt);
        chk("done_seen", done_seen, e.dn);
      end
    end
  end

  task automatic idle(input int cycles, input bit rnd);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clock);
      start    = 1'b0;
      tog_out  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      tog_done = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      last_tog = tog_out;
    end
  endtask

  // mode 0: random tog/done and spurious starts; 1: alternating tog; 2: quiet; 3: one done pulse
  task automatic run(input int h, input int l, input int b, input int mode);
    exp_t e;
    int   gap, n, c;
    bit   acc, lt, d;
    bit   tg[HW];
    bit   dp[HW];
    gap = (l == 0) ? 1 : l;
    acc = (b != 0) && (h != 0);
    n   = acc ? b * h + (b - 1) * gap : 0;
    e.rdy = '0;
    e.bsy = '0;
    for (int i = 1; i <= n; i++) begin
      e.bsy[i] = 1'b1;
      e.rdy[i] = ((i - 1) % (h + gap)) < h;
    end
    lt = last_tog; c = 0; d = 1'b0;
    for (int j = 0; j <= n + 1; j++) begin
      case (mode)
        0:       begin tg[j] = 1'($urandom_range(0, 1)); dp[j] = ($urandom_range(0, 15) == 0); end
        1:       begin tg[j] = (j == 0) || (j % 2 == 1); dp[j] = 1'b0; end
        3:       begin tg[j] = 1'b0; dp[j] = (j == n / 2 + 1); end
        default: begin tg[j] = 1'b0; dp[j] = 1'b0; end
      endcase
      if (j >= 1 && j <= n) begin
        if (tg[j] && !lt) c++;
        if (dp[j]) d = 1'b1;
      end
      lt = tg[j];
    end
    e.n   = n;
    e.cnt = (c > 255) ? 255 : c;
    e.dn  = d;
    @(negedge clock);
    chk("hold_edge_count_before_start", edge_count, prev_cnt);
    chk("hold_done_seen_before_start", done_seen, prev_dn);
    e.fin_cyc = cyc + n + 1;
    q.push_back(e);
    for (int j = 0; j <= n + 1; j++) begin
      if (j > 0) @(negedge clock);
      if (j == 0) begin
        start = 1'b1; high_len = CW'(h); low_len = CW'(l); bursts = BW'(b);
      end else begin
        start    = (mode == 0) && (j <= n) && ($urandom_range(0, 7) == 0);
        high_len = CW'($urandom); low_len = CW'($urandom); bursts = BW'($urandom);
      end
      tog_out  = tg[j];
      tog_done = dp[j];
    end
    last_tog = lt;
    prev_cnt = e.cnt;
    prev_dn  = e.dn;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; tog_out = 1'b0; tog_done = 1'b0;
    high_len = '0; low_len = '0; bursts = '0;
    #2;
    chk("reset_ready", ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_finished", finished, 0);
    chk("reset_edge_count", edge_count, 0);
    chk("reset_done_seen", done_seen, 0);
    @(negedge clock);
    reset = 1'b0;
    idle(2, 1'b0);

    run(4, 4, 2, 2);
    idle(3, 1'b1);
    run(5, 2, 0, 0);
    run(0, 3, 4, 0);
    run(2, 0, 3, 2);
    idle(2, 1'b0);
    run(255, 0, 3, 1);
    run(6, 3, 3, 3);
    run(3, 1, 2, 2);

    // reset in the middle of a HIGH burst must drop outputs without a clock
    @(negedge clock);
    start = 1'b1; high_len = 8'd8; low_len = 8'd1; bursts = 4'd2;
    tog_out = 1'b0; tog_done = 1'b0;
    repeat (3) begin
      @(negedge clock);
      start = 1'b0;
    end
    chk("ready_high_before_reset", ready, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_ready", ready, 0);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_finished", finished, 0);
    chk("async_reset_edge_count", edge_count, 0);
    @(negedge clock);
    reset = 1'b0;
    last_tog = 1'b0; prev_cnt = 0; prev_dn = 1'b0;
    run(3, 2, 2, 0);

    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4), 1'b1);
      run($urandom_range(0, 8), $urandom_range(0, 5), $urandom_range(0, 5), 0);
    end

    repeat (2) @(negedge clock);
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clock);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
